// File: rtl/star_scan_scheduler.sv
// ============================================================================
// Module   : star_scan_scheduler
// Function : Raster-scans an image RAM, launches a star finder on each lit,
//            uncovered pixel and keeps a small table of bounding boxes.
// Revision : 1.0
// ============================================================================
`default_nettype none

module star_scan_scheduler #(
    parameter int XSZ       = 3,
    parameter int YSZ       = 3,
    parameter int ADDRSZ    = 6,
    parameter int COLSZ     = 3,
    parameter int WIDTH     = 6,
    parameter int HEIGHT    = 6,
    parameter int THRESHOLD = 0,
    parameter int MAXSTARS  = 4,
    parameter int TIMEOUT   = 63
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDRSZ-1:0] mem_addr,
    input  logic [COLSZ-1:0]  pix_val,
    output logic              find_start,
    output logic [XSZ-1:0]    find_x,
    output logic [YSZ-1:0]    find_y,
    input  logic              find_done,
    input  logic [XSZ-1:0]    find_left,
    input  logic [XSZ-1:0]    find_right,
    input  logic [YSZ-1:0]    find_top,
    input  logic [YSZ-1:0]    find_bottom,
    output logic              busy,
    output logic              done,
    output logic [2:0]        star_count,
    input  logic [1:0]        rd_idx,
    output logic [XSZ-1:0]    rd_left,
    output logic [XSZ-1:0]    rd_right,
    output logic [YSZ-1:0]    rd_top,
    output logic [YSZ-1:0]    rd_bottom,
    output logic              overflow,
    output logic              timeout_err
);

    localparam int c_WDW = $clog2(TIMEOUT + 1);
    localparam int c_SLW = (MAXSTARS > 1) ? $clog2(MAXSTARS) : 1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_READ      = 3'd1,
        S_CHECK     = 3'd2,
        S_LAUNCH    = 3'd3,
        S_WAIT_FIND = 3'd4,
        S_ADVANCE   = 3'd5,
        S_DONE      = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic [XSZ-1:0]     x_q, x_d;
    logic [YSZ-1:0]     y_q, y_d;
    logic [c_WDW-1:0]   wd_q, wd_d;
    logic [2:0]         cnt_q, cnt_d;
    logic [MAXSTARS-1:0] valid_q, valid_d;
    logic [XSZ-1:0]     left_q [MAXSTARS];
    logic [XSZ-1:0]     left_d [MAXSTARS];
    logic [XSZ-1:0]     right_q [MAXSTARS];
    logic [XSZ-1:0]     right_d [MAXSTARS];
    logic [YSZ-1:0]     top_q [MAXSTARS];
    logic [YSZ-1:0]     top_d [MAXSTARS];
    logic [YSZ-1:0]     bottom_q [MAXSTARS];
    logic [YSZ-1:0]     bottom_d [MAXSTARS];
    logic [XSZ-1:0]     fx_q, fx_d;
    logic [YSZ-1:0]     fy_q, fy_d;
    logic               ovf_q, ovf_d;
    logic               tmo_q, tmo_d;
    logic               w_covered;
    logic               w_lit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            wd_q    <= '0;
            cnt_q   <= '0;
            valid_q <= '0;
            fx_q    <= '0;
            fy_q    <= '0;
            ovf_q   <= 1'b0;
            tmo_q   <= 1'b0;
            for (int i = 0; i < MAXSTARS; i++) begin
                left_q[i]   <= '0;
                right_q[i]  <= '0;
                top_q[i]    <= '0;
                bottom_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            wd_q     <= wd_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            fx_q     <= fx_d;
            fy_q     <= fy_d;
            ovf_q    <= ovf_d;
            tmo_q    <= tmo_d;
            left_q   <= left_d;
            right_q  <= right_d;
            top_q    <= top_d;
            bottom_q <= bottom_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        wd_d     = wd_q;
        cnt_d    = cnt_q;
        valid_d  = valid_q;
        fx_d     = fx_q;
        fy_d     = fy_q;
        ovf_d    = ovf_q;
        tmo_d    = tmo_q;
        left_d   = left_q;
        right_d  = right_q;
        top_d    = top_q;
        bottom_d = bottom_q;

        w_lit     = (pix_val > COLSZ'(THRESHOLD));
        w_covered = 1'b0;
        for (int i = 0; i < MAXSTARS; i++) begin
            if (valid_q[i] && (left_q[i] <= x_q) && (x_q <= right_q[i]) &&
                (top_q[i] <= y_q) && (y_q <= bottom_q[i])) begin
                w_covered = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_d     = '0;
                    y_d     = '0;
                    cnt_d   = '0;
                    valid_d = '0;
                    ovf_d   = 1'b0;
                    tmo_d   = 1'b0;
                    state_d = S_READ;
                end
            end
            S_READ: state_d = S_CHECK;
            S_CHECK: begin
                if (w_lit && !w_covered) begin
                    if (cnt_q < 3'(MAXSTARS)) begin
                        fx_d    = x_q;
                        fy_d    = y_q;
                        state_d = S_LAUNCH;
                    end else begin
                        ovf_d   = 1'b1;
                        state_d = S_ADVANCE;
                    end
                end else begin
                    state_d = S_ADVANCE;
                end
            end
            S_LAUNCH: begin
                wd_d    = '0;
                state_d = S_WAIT_FIND;
            end
            S_WAIT_FIND: begin
                // A result arriving on the watchdog's last cycle still counts.
                if (find_done) begin
                    left_d[cnt_q[c_SLW-1:0]]   = find_left;
                    right_d[cnt_q[c_SLW-1:0]]  = find_right;
                    top_d[cnt_q[c_SLW-1:0]]    = find_top;
                    bottom_d[cnt_q[c_SLW-1:0]] = find_bottom;
                    valid_d[cnt_q[c_SLW-1:0]]  = 1'b1;
                    cnt_d   = cnt_q + 3'd1;
                    state_d = S_ADVANCE;
                end else if (wd_q == c_WDW'(TIMEOUT)) begin
                    tmo_d   = 1'b1;
                    state_d = S_ADVANCE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_ADVANCE: begin
                if (x_q == XSZ'(WIDTH - 1)) begin
                    if (y_q == YSZ'(HEIGHT - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        x_d     = '0;
                        y_d     = y_q + 1'b1;
                        state_d = S_READ;
                    end
                end else begin
                    x_d     = x_q + 1'b1;
                    state_d = S_READ;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign mem_addr    = ADDRSZ'(y_q) * ADDRSZ'(WIDTH) + ADDRSZ'(x_q);
    assign find_start  = (state_q == S_LAUNCH);
    assign find_x      = fx_q;
    assign find_y      = fy_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign star_count  = cnt_q;
    assign overflow    = ovf_q;
    assign timeout_err = tmo_q;

    // Stale box data stays in the table after a restart; the valid bit masks it.
    assign rd_left   = valid_q[rd_idx] ? left_q[rd_idx]   : '0;
    assign rd_right  = valid_q[rd_idx] ? right_q[rd_idx]  : '0;
    assign rd_top    = valid_q[rd_idx] ? top_q[rd_idx]    : '0;
    assign rd_bottom = valid_q[rd_idx] ? bottom_q[rd_idx] : '0;

endmodule

`default_nettype wire

// File: tb/tb_star_scan_scheduler.sv
// ============================================================================
// Module   : tb_star_scan_scheduler
// Function : Table-driven bench with an image RAM model and a star finder model.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_star_scan_scheduler;

    logic       clk;
    logic       reset;
    logic       start;
    logic [5:0] mem_addr;
    logic [2:0] pix_val;
    logic       find_start;
    logic [2:0] find_x, find_y;
    logic       find_done;
    logic [2:0] find_left, find_right, find_top, find_bottom;
    logic       busy, done;
    logic [2:0] star_count;
    logic [1:0] rd_idx;
    logic [2:0] rd_left, rd_right, rd_top, rd_bottom;
    logic       overflow, timeout_err;

    star_scan_scheduler dut (
        .clk(clk), .reset(reset), .start(start), .mem_addr(mem_addr),
        .pix_val(pix_val), .find_start(find_start), .find_x(find_x),
        .find_y(find_y), .find_done(find_done), .find_left(find_left),
        .find_right(find_right), .find_top(find_top),
        .find_bottom(find_bottom), .busy(busy), .done(done),
        .star_count(star_count), .rd_idx(rd_idx), .rd_left(rd_left),
        .rd_right(rd_right), .rd_top(rd_top), .rd_bottom(rd_bottom),
        .overflow(overflow), .timeout_err(timeout_err)
    );

    typedef struct {
        logic [35:0] lit;
        int val, fdelay, fixed, bl, br, bt, bb;
        int exp_launch, exp_fx, exp_fy, exp_cnt, exp_ovf, exp_to, exp_done;
        int chk_idx, el, er, et, eb;
    } vec_t;

    vec_t       vt [6];
    logic [2:0] img [64];
    int         n_vec = 0;
    int         n_bad = 0;
    int         launches = 0;
    int         first_fx = -1, first_fy = -1;
    int         cur_delay = 0, cur_fixed = 0;
    int         cur_bl = 0, cur_br = 0, cur_bt = 0, cur_bb = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [35:0] px(input int x, input int y);
        logic [35:0] m;
        m = '0;
        m[y*6 + x] = 1'b1;
        return m;
    endfunction

    // Image RAM with one cycle of read latency
    initial begin
        int a;
        pix_val = '0;
        forever begin
            @(negedge clk);
            a = int'(mem_addr);
            @(posedge clk);
            #1 pix_val = img[a];
        end
    end

    // Star finder: answers cur_delay cycles after the launch, or never if 0
    initial begin
        int lx, ly;
        find_done = 1'b0;
        find_left = '0; find_right = '0; find_top = '0; find_bottom = '0;
        forever begin
            @(negedge clk);
            if (find_start) begin
                launches++;
                lx = int'(find_x);
                ly = int'(find_y);
                if (launches == 1) begin
                    first_fx = lx;
                    first_fy = ly;
                end
                if (cur_delay > 0) begin
                    repeat (cur_delay) @(posedge clk);
                    #1;
                    find_left   = 3'(cur_fixed ? cur_bl : lx);
                    find_right  = 3'(cur_fixed ? cur_br : lx);
                    find_top    = 3'(cur_fixed ? cur_bt : ly);
                    find_bottom = 3'(cur_fixed ? cur_bb : ly);
                    find_done   = 1'b1;
                    @(negedge clk);
                    if (busy) begin
                        chk("find_x_hold", int'(find_x), lx);
                        chk("find_y_hold", int'(find_y), ly);
                    end
                    @(posedge clk);
                    #1 find_done = 1'b0;
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "bench watchdog expired");
    end

    task automatic run_vec(input int k, input vec_t v);
        int cyc;
        for (int i = 0; i < 64; i++)
            img[i] = (i < 36 && v.lit[i % 36]) ? 3'(v.val) : 3'd0;
        cur_delay = v.fdelay; cur_fixed = v.fixed;
        cur_bl = v.bl; cur_br = v.br; cur_bt = v.bt; cur_bb = v.bb;
        launches = 0; first_fx = -1; first_fy = -1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        cyc = 1;
        chk($sformatf("v%0d busy_run", k), int'(busy), 1);
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        chk($sformatf("v%0d done_cycle", k), cyc, v.exp_done);
        @(negedge clk);
        chk($sformatf("v%0d done_pulse", k), int'(done), 0);
        chk($sformatf("v%0d busy_idle", k), int'(busy), 0);
        chk($sformatf("v%0d launches", k), launches, v.exp_launch);
        if (v.exp_launch > 0) begin
            chk($sformatf("v%0d first_fx", k), first_fx, v.exp_fx);
            chk($sformatf("v%0d first_fy", k), first_fy, v.exp_fy);
        end
        chk($sformatf("v%0d star_count", k), int'(star_count), v.exp_cnt);
        chk($sformatf("v%0d overflow", k), int'(overflow), v.exp_ovf);
        chk($sformatf("v%0d timeout_err", k), int'(timeout_err), v.exp_to);
        rd_idx = 2'(v.chk_idx);
        #1;
        chk($sformatf("v%0d rd_left", k), int'(rd_left), v.el);
        chk($sformatf("v%0d rd_right", k), int'(rd_right), v.er);
        chk($sformatf("v%0d rd_top", k), int'(rd_top), v.et);
        chk($sformatf("v%0d rd_bottom", k), int'(rd_bottom), v.eb);
    endtask

    initial begin
        logic [35:0] stars, blk;
        int wcyc;
        reset = 1'b1; start = 1'b0; rd_idx = 2'd0;
        for (int i = 0; i < 64; i++) img[i] = 3'd0;

        stars = px(0, 0) | px(2, 0) | px(4, 0) | px(1, 2) | px(3, 4);
        blk = '0;
        for (int yy = 0; yy <= 2; yy++)
            for (int xx = 1; xx <= 3; xx++)
                blk = blk | px(xx, yy);

        //           lit     val dly fx bl br bt bb  ln fx fy cnt ov to done idx el er et eb
        vt[0] = '{px(2, 1), 5,  3, 1, 2, 2, 1, 1, 1, 2, 1, 1, 0, 0, 113, 0, 2, 2, 1, 1};
        vt[1] = '{px(2, 1), 5,  0, 0, 0, 0, 0, 0, 1, 2, 1, 0, 0, 1, 174, 0, 0, 0, 0, 0};
        vt[2] = '{36'd0,    5,  3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 109, 0, 0, 0, 0, 0};
        vt[3] = '{stars,    1,  3, 0, 0, 0, 0, 0, 4, 0, 0, 4, 1, 0, 125, 3, 1, 1, 2, 2};
        vt[4] = '{blk,      5,  3, 1, 1, 3, 0, 2, 1, 1, 0, 1, 0, 0, 113, 0, 1, 3, 0, 2};
        vt[5] = '{px(5, 5), 5, 64, 0, 0, 0, 0, 0, 1, 5, 5, 1, 0, 0, 174, 0, 5, 5, 5, 5};

        repeat (3) @(negedge clk);
        chk("rst busy", int'(busy), 0);
        chk("rst done", int'(done), 0);
        chk("rst find_start", int'(find_start), 0);
        chk("rst find_x", int'(find_x), 0);
        chk("rst find_y", int'(find_y), 0);
        chk("rst star_count", int'(star_count), 0);
        chk("rst overflow", int'(overflow), 0);
        chk("rst timeout_err", int'(timeout_err), 0);
        chk("rst mem_addr", int'(mem_addr), 0);
        chk("rst rd_left", int'(rd_left), 0);
        reset = 1'b0;

        for (int k = 0; k < 6; k++) run_vec(k, vt[k]);

        // Reset in the middle of WAIT_FIND; the finder answers after the reset.
        for (int i = 0; i < 64; i++) img[i] = 3'd0;
        img[0] = 3'd7;
        cur_delay = 20; cur_fixed = 0; launches = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        wcyc = 0;
        while (launches == 0 && wcyc < 50) begin
            @(negedge clk);
            wcyc++;
        end
        chk("rstwait launch_seen", launches, 1);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rstwait busy", int'(busy), 0);
        chk("rstwait find_start", int'(find_start), 0);
        chk("rstwait star_count", int'(star_count), 0);
        chk("rstwait find_x", int'(find_x), 0);
        reset = 1'b0;
        repeat (25) @(negedge clk);
        chk("late_done busy", int'(busy), 0);
        chk("late_done star_count", int'(star_count), 0);
        rd_idx = 2'd0;
        #1 chk("late_done rd_right", int'(rd_right), 0);

        // Reset wins over start on the same edge.
        @(negedge clk);
        reset = 1'b1; start = 1'b1;
        @(negedge clk);
        chk("rst_vs_start busy", int'(busy), 0);
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("rst_vs_start idle", int'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
